// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared state encoding and sizing helper for the serial adder.
// Contents:
//   IDLE/RUN/DONE - FSM state codes
//   state_e       - typed FSM state built on those codes
//   cnt_width()   - width of the step counter, clog2(steps) but never below 1
package serial_adder_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    typedef enum logic [1:0] {
        StIdle = IDLE,
        StRun  = RUN,
        StDone = DONE
    } state_e;

    function automatic int unsigned cnt_width(input int unsigned steps);
        return (steps > 1) ? $clog2(steps) : 1;
    endfunction

endpackage

// File: rtl/serial_adder_if.sv
// serial_adder_if: operand/result handshake bundle for serial_adder.
// Signals:
//   in_valid/in_ready   - operand handshake (producer -> adder)
//   a, b, cin           - operands and carry-in
//   out_valid/out_ready - result handshake (adder -> consumer)
//   sum, cout           - result and carry-out
//   sub, overflow       - subtract select and signed overflow (SERIAL_ADDER_SUB_EN only)
// Modports: master (producer/consumer side), slave (adder side).
interface serial_adder_if
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef SERIAL_ADDER_SUB_EN
    logic             sub;
    logic             overflow;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, overflow
    );
    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, overflow
    );
`else
    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout
    );
    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout
    );
`endif
endinterface

// File: rtl/serial_adder_fa_slice.sv
// fa_slice: combinational ripple chain of BPC one-bit full adders.
// Ports:
//   a, b     - BPC operand bits (LSB first)
//   ci       - carry into cell 0
//   s        - BPC sum bits
//   co       - carry out of the top cell
//   c_msb_in - carry into the top cell (for signed overflow detection)
module fa_slice
    import serial_adder_pkg::*;
#(
    parameter int unsigned BPC = 1
) (
    input  logic [BPC-1:0] a,
    input  logic [BPC-1:0] b,
    input  logic           ci,
    output logic [BPC-1:0] s,
    output logic           co,
    output logic           c_msb_in
);

    always_comb begin
        logic [BPC:0] c;
        c    = '0;
        s    = '0;
        c[0] = ci;
        for (int i = 0; i < BPC; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        co       = c[BPC];
        c_msb_in = c[BPC-1];
    end

endmodule

// File: rtl/serial_adder.sv
// serial_adder: multi-cycle adder, BPC bits per clock through one fa_slice.
// Ports:
//   clk   - rising-edge clock
//   rst_n - synchronous active-low reset
//   bus   - serial_adder_if.slave: operand and result valid/ready handshakes
// Parameters: WIDTH (>= 2), BPC (must divide WIDTH). STEPS = WIDTH/BPC cycles in RUN.
// Optional: define SERIAL_ADDER_SUB_EN for sub/overflow (a-b in two's complement).
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned BPC   = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    serial_adder_if.slave bus
);

    localparam int unsigned STEPS = WIDTH / BPC;
    localparam int unsigned CW    = cnt_width(STEPS);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sha_q, sha_d;
    logic [WIDTH-1:0] shb_q, shb_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic [CW-1:0]    count_q, count_d;

    logic [BPC-1:0]   s_sum;
    logic             s_co;
    logic             s_cmsb;

    fa_slice #(
        .BPC (BPC)
    ) u_slice (
        .a        (sha_q[BPC-1:0]),
        .b        (shb_q[BPC-1:0]),
        .ci       (carry_q),
        .s        (s_sum),
        .co       (s_co),
        .c_msb_in (s_cmsb)
    );

`ifdef SERIAL_ADDER_SUB_EN
    logic ovf_q, ovf_d;
`else
    logic unused_cmsb;
    assign unused_cmsb = s_cmsb;
`endif

    always_comb begin
        state_d = state_q;
        sha_d   = sha_q;
        shb_d   = shb_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        count_d = count_q;
`ifdef SERIAL_ADDER_SUB_EN
        ovf_d   = ovf_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    sha_d   = bus.a;
                    shb_d   = bus.b;
                    carry_d = bus.cin;
`ifdef SERIAL_ADDER_SUB_EN
                    // a + ~b + 1 == a - b; cin is ignored for subtraction
                    if (bus.sub) begin
                        shb_d   = ~bus.b;
                        carry_d = 1'b1;
                    end
`endif
                    count_d = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                sha_d   = sha_q >> BPC;
                shb_d   = shb_q >> BPC;
                // Result bits enter at the top and migrate down to their final position
                sum_d   = (sum_q >> BPC) | (WIDTH'(s_sum) << (WIDTH - BPC));
                carry_d = s_co;
                count_d = count_q + CW'(1);
                if (count_q == CW'(STEPS - 1)) begin
                    cout_d  = s_co;
`ifdef SERIAL_ADDER_SUB_EN
                    ovf_d   = s_cmsb ^ s_co;
`endif
                    state_d = StDone;
                end
            end
            StDone: begin
                if (bus.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            sha_q   <= '0;
            shb_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            count_q <= '0;
`ifdef SERIAL_ADDER_SUB_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sha_q   <= sha_d;
            shb_q   <= shb_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            count_q <= count_d;
`ifdef SERIAL_ADDER_SUB_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign bus.in_ready  = (state_q == StIdle);
    assign bus.out_valid = (state_q == StDone);
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
`ifdef SERIAL_ADDER_SUB_EN
    assign bus.overflow  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: self-checking bench for serial_adder (WIDTH=8, BPC=1 and BPC=4).
// Reference: plain integer arithmetic on the operands. Optional sub tests run
// when SERIAL_ADDER_SUB_EN is defined.
module tb_serial_adder;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    serial_adder_if #(.WIDTH(W)) bus1 ();
    serial_adder_if #(.WIDTH(W)) bus4 ();

    serial_adder #(.WIDTH(W), .BPC(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    serial_adder #(.WIDTH(W), .BPC(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4)
    );

    int errors = 0;
    int checks = 0;

    // {cout,sum} as the integer a+b+cin, or a-b+2^W for subtraction (bit W = no borrow)
    function automatic logic [W:0] ref_sum(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic cin, input logic sub);
        int r;
        if (sub) r = int'(a) - int'(b) + (1 << W);
        else     r = int'(a) + int'(b) + int'(cin);
        return r[W:0];
    endfunction

    // Signed overflow: exact signed result outside the W-bit two's complement range
    function automatic logic ref_ovf(input logic [W-1:0] a, input logic [W-1:0] b,
                                     input logic cin, input logic sub);
        int sa, sb, e;
        sa = int'(a) - (a[W-1] ? (1 << W) : 0);
        sb = int'(b) - (b[W-1] ? (1 << W) : 0);
        e  = sub ? (sa - sb) : (sa + sb + int'(cin));
        return (e < -(1 << (W - 1))) || (e > (1 << (W - 1)) - 1);
    endfunction

    task automatic idle_inputs();
        bus1.in_valid = 1'b0; bus1.a = '0; bus1.b = '0; bus1.cin = 1'b0; bus1.out_ready = 1'b0;
        bus4.in_valid = 1'b0; bus4.a = '0; bus4.b = '0; bus4.cin = 1'b0; bus4.out_ready = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
        bus1.sub = 1'b0;
        bus4.sub = 1'b0;
`endif
    endtask

    // One transaction on the BPC=1 instance. hold = extra DONE cycles with out_ready=0,
    // pulses = drive random junk on the input side during RUN.
    task automatic do_op1(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                          input logic sub, input int hold, input bit pulses, input string nm);
        logic [W:0]   exp;
        logic [W-1:0] held;
        int           n;
        exp = ref_sum(a, b, cin, sub);
        @(negedge clk);
        checks++;
        if (bus1.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s in_ready_idle: got %b want 1", nm, bus1.in_ready);
        end
        bus1.in_valid = 1'b1; bus1.a = a; bus1.b = b; bus1.cin = cin;
`ifdef SERIAL_ADDER_SUB_EN
        bus1.sub = sub;
`endif
        @(posedge clk);
        @(negedge clk);
        bus1.in_valid = 1'b0;
        bus1.a = W'($urandom); bus1.b = W'($urandom); bus1.cin = 1'($urandom);
        n = 0;
        while (bus1.out_valid !== 1'b1 && n < 40) begin
            checks++;
            if (bus1.in_ready !== 1'b0) begin
                errors++;
                $display("FAIL %s in_ready_run: got %b want 0 at step %0d", nm, bus1.in_ready, n);
            end
            if (pulses) begin
                bus1.in_valid = 1'($urandom);
                bus1.a = W'($urandom); bus1.b = W'($urandom);
            end
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        bus1.in_valid = 1'b0;
        // out_valid appears 8 edges after the handshake edge (9 counting that edge)
        checks++;
        if (n != 8) begin
            errors++;
            $display("FAIL %s latency: got %0d edges want 8", nm, n);
            return;
        end
        checks++;
        if (bus1.sum !== exp[W-1:0]) begin
            errors++;
            $display("FAIL %s sum: got %h want %h", nm, bus1.sum, exp[W-1:0]);
        end
        checks++;
        if (bus1.cout !== exp[W]) begin
            errors++;
            $display("FAIL %s cout: got %b want %b", nm, bus1.cout, exp[W]);
        end
`ifdef SERIAL_ADDER_SUB_EN
        checks++;
        if (bus1.overflow !== ref_ovf(a, b, cin, sub)) begin
            errors++;
            $display("FAIL %s overflow: got %b want %b", nm, bus1.overflow, ref_ovf(a, b, cin, sub));
        end
`endif
        held = bus1.sum;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (bus1.out_valid !== 1'b1 || bus1.sum !== exp[W-1:0]) begin
                errors++;
                $display("FAIL %s backpressure: got valid=%b sum=%h want valid=1 sum=%h",
                         nm, bus1.out_valid, bus1.sum, exp[W-1:0]);
            end
        end
        bus1.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus1.out_ready = 1'b0;
        checks++;
        if (bus1.out_valid !== 1'b0 || bus1.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s release: got valid=%b ready=%b want valid=0 ready=1",
                     nm, bus1.out_valid, bus1.in_ready);
        end
        if (held !== exp[W-1:0]) ;
    endtask

    // One transaction on the BPC=4 instance (2 steps).
    task automatic do_op4(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                          input int hold, input string nm);
        logic [W:0] exp;
        int         n;
        exp = ref_sum(a, b, cin, 1'b0);
        @(negedge clk);
        bus4.in_valid = 1'b1; bus4.a = a; bus4.b = b; bus4.cin = cin;
        @(posedge clk);
        @(negedge clk);
        bus4.in_valid = 1'b0;
        n = 0;
        while (bus4.out_valid !== 1'b1 && n < 40) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        checks++;
        if (n != 2) begin
            errors++;
            $display("FAIL %s latency: got %0d edges want 2", nm, n);
            return;
        end
        checks++;
        if (bus4.sum !== exp[W-1:0] || bus4.cout !== exp[W]) begin
            errors++;
            $display("FAIL %s result: got cout=%b sum=%h want cout=%b sum=%h",
                     nm, bus4.cout, bus4.sum, exp[W], exp[W-1:0]);
        end
        repeat (hold) @(posedge clk);
        @(negedge clk);
        bus4.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus4.out_ready = 1'b0;
        checks++;
        if (bus4.in_ready !== 1'b1 || bus4.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s release: got ready=%b valid=%b want ready=1 valid=0",
                     nm, bus4.in_ready, bus4.out_valid);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if (bus1.in_ready !== 1'b1 || bus1.out_valid !== 1'b0 || bus1.sum !== '0 ||
            bus1.cout !== 1'b0) begin
            errors++;
            $display("FAIL reset1: got ready=%b valid=%b sum=%h cout=%b want 1 0 00 0",
                     bus1.in_ready, bus1.out_valid, bus1.sum, bus1.cout);
        end
        checks++;
        if (bus4.in_ready !== 1'b1 || bus4.out_valid !== 1'b0 || bus4.sum !== '0) begin
            errors++;
            $display("FAIL reset4: got ready=%b valid=%b sum=%h want 1 0 00",
                     bus4.in_ready, bus4.out_valid, bus4.sum);
        end
    endtask

    task automatic test_directed();
        do_op1(8'hFF, 8'h01, 1'b0, 1'b0, 0, 1'b0, "ff_plus_01");
        do_op1(8'h03, 8'h05, 1'b1, 1'b0, 0, 1'b1, "ignore_pulses");
        // Exactly one result: nothing may appear while idle afterwards
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            checks++;
            if (bus1.out_valid !== 1'b0) begin
                errors++;
                $display("FAIL extra_result: got out_valid=%b want 0 at idle cycle %0d",
                         bus1.out_valid, i);
            end
        end
    endtask

    task automatic test_backpressure();
        do_op1(8'h5A, 8'h3C, 1'b0, 1'b0, 5, 1'b0, "backpressure");
    endtask

    task automatic test_mid_reset();
        @(negedge clk);
        bus1.in_valid = 1'b1; bus1.a = 8'hAA; bus1.b = 8'h55; bus1.cin = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus1.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if (bus1.out_valid !== 1'b0 || bus1.in_ready !== 1'b1 || bus1.sum !== 8'h00) begin
            errors++;
            $display("FAIL mid_reset: got valid=%b ready=%b sum=%h want 0 1 00",
                     bus1.out_valid, bus1.in_ready, bus1.sum);
        end
        do_op1(8'h10, 8'h20, 1'b0, 1'b0, 0, 1'b0, "after_reset");
    endtask

    task automatic test_bpc4();
        do_op4(8'hAB, 8'h77, 1'b0, 0, "bpc4_ab_77");
        for (int i = 0; i < 8; i++) begin
            do_op4(W'($urandom), W'($urandom), 1'($urandom), $urandom_range(0, 3), "bpc4_rand");
        end
    endtask

    task automatic test_random();
        logic s;
        for (int i = 0; i < 20; i++) begin
            s = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
            s = 1'($urandom);
`endif
            do_op1(W'($urandom), W'($urandom), 1'($urandom), s, $urandom_range(0, 3),
                   1'b1, "random");
        end
    endtask

`ifdef SERIAL_ADDER_SUB_EN
    task automatic test_sub();
        do_op1(8'h05, 8'h07, 1'b0, 1'b1, 0, 1'b0, "sub_05_07");
        do_op1(8'h80, 8'h01, 1'b1, 1'b1, 0, 1'b0, "sub_80_01");
        do_op1(8'h7F, 8'h01, 1'b0, 1'b0, 0, 1'b0, "add_ovf");
    endtask
`endif

    initial begin
        idle_inputs();
        rst_n = 1'b1;
        test_reset();
        test_directed();
        test_backpressure();
        test_mid_reset();
        test_bpc4();
`ifdef SERIAL_ADDER_SUB_EN
        test_sub();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
